// File: rtl/log_mem_ctrl_if.sv
// -----------------------------------------------------------------------------
// log_mem_ctrl_if
// Bus between the register file's logging controls / datapath and the capture
// memory controller.
//
// Signals:
//   i_run_log   capture start; a 0->1 step on consecutive clocks starts a burst
//   i_read_log  read enable, level-sensitive
//   i_addr_log  read address, sampled every clock while i_read_log=1
//   i_data      sample word from the datapath
//   i_valid     sample strobe; one word is written per strobe during capture
//   o_data_log  registered read data
//   o_mem_full  burst complete, RAM holds a full capture
//   o_busy      capture in progress
//
// Modports:
//   master  register file / datapath side (drives the i_* signals)
//   slave   capture memory controller side (drives the o_* signals)
// -----------------------------------------------------------------------------
interface log_mem_ctrl_if #(
    parameter int NB_ADDR_MEM = 15,
    parameter int NB_DATA     = 32
) ();

    logic                   i_run_log;
    logic                   i_read_log;
    logic [NB_ADDR_MEM-1:0] i_addr_log;
    logic [NB_DATA-1:0]     i_data;
    logic                   i_valid;
    logic [NB_DATA-1:0]     o_data_log;
    logic                   o_mem_full;
    logic                   o_busy;

    modport master (
        output i_run_log,
        output i_read_log,
        output i_addr_log,
        output i_data,
        output i_valid,
        input  o_data_log,
        input  o_mem_full,
        input  o_busy
    );

    modport slave (
        input  i_run_log,
        input  i_read_log,
        input  i_addr_log,
        input  i_data,
        input  i_valid,
        output o_data_log,
        output o_mem_full,
        output o_busy
    );

endinterface

// File: rtl/log_mem_ctrl.sv
// -----------------------------------------------------------------------------
// log_mem_ctrl
// Capture memory for datapath logging. A rising edge on the run control
// records a contiguous burst of 2**NB_ADDR_MEM valid samples into an internal
// RAM (synchronous write, registered read, no reset on the array). When the
// last word lands the full flag rises and writing stops until the next run
// edge. The read port returns RAM[i_addr_log] one clock after the address is
// presented while reading is enabled, and holds its value otherwise.
//
// Ports:
//   clk    system clock, rising edge
//   i_rst  synchronous active-high reset (RAM contents are preserved)
//   bus    log_mem_ctrl_if.slave: run/read controls, read address, sample
//          data/strobe in; read data, full and busy flags out
// -----------------------------------------------------------------------------
module log_mem_ctrl #(
    parameter int NB_ADDR_MEM = 15,
    parameter int NB_DATA     = 32
) (
    input  logic           clk,
    input  logic           i_rst,
    log_mem_ctrl_if.slave  bus
);

    localparam int DEPTH = 2 ** NB_ADDR_MEM;

    localparam logic [NB_ADDR_MEM-1:0] ADDR_ZERO = {NB_ADDR_MEM{1'b0}};
    localparam logic [NB_ADDR_MEM-1:0] ADDR_ONE  = {{(NB_ADDR_MEM-1){1'b0}}, 1'b1};
    localparam logic [NB_ADDR_MEM-1:0] ADDR_LAST = {NB_ADDR_MEM{1'b1}};
    localparam logic [NB_DATA-1:0]     DATA_ZERO = {NB_DATA{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_CAPTURE = 2'b01,
        ST_FULL    = 2'b10
    } state_t;

    // Capture RAM: written only by the capture FSM, read by the read port.
    logic [NB_DATA-1:0]     mem_r [DEPTH];

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [NB_ADDR_MEM-1:0] wr_ptr_r;
    logic [NB_ADDR_MEM-1:0] wr_ptr_nxt_s;
    logic                   run_d_r;
    logic                   run_edge_s;
    logic                   we_s;
    logic                   wr_en_s;
    logic                   busy_r;
    logic                   busy_nxt_s;
    logic                   full_r;
    logic                   full_nxt_s;
    logic [NB_DATA-1:0]     data_log_r;

    // A held-high run level yields one edge only, so one burst per press.
    assign run_edge_s = bus.i_run_log & ~run_d_r;

    // Run control delay register for the rising-edge detector.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            run_d_r <= 1'b0;
        end else begin
            run_d_r <= bus.i_run_log;
        end
    end

    // Capture FSM state, write pointer and status flag registers.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_r  <= ST_IDLE;
            wr_ptr_r <= ADDR_ZERO;
            busy_r   <= 1'b0;
            full_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            wr_ptr_r <= wr_ptr_nxt_s;
            busy_r   <= busy_nxt_s;
            full_r   <= full_nxt_s;
        end
    end

    // Next-state, pointer update and write strobe for the capture FSM.
    always_comb begin
        state_nxt_s  = state_r;
        wr_ptr_nxt_s = wr_ptr_r;
        we_s         = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (run_edge_s) begin
                    state_nxt_s  = ST_CAPTURE;
                    wr_ptr_nxt_s = ADDR_ZERO;
                end else begin
                    state_nxt_s  = ST_IDLE;
                    wr_ptr_nxt_s = wr_ptr_r;
                end
            end
            ST_CAPTURE: begin
                if (run_edge_s) begin
                    // Restart: the sample in this cycle is dropped on purpose
                    // so the new burst starts cleanly at address 0.
                    state_nxt_s  = ST_CAPTURE;
                    wr_ptr_nxt_s = ADDR_ZERO;
                end else if (bus.i_valid) begin
                    we_s         = 1'b1;
                    // Pointer wraps to 0 naturally after the last address.
                    wr_ptr_nxt_s = wr_ptr_r + ADDR_ONE;
                    if (wr_ptr_r == ADDR_LAST) begin
                        state_nxt_s = ST_FULL;
                    end else begin
                        state_nxt_s = ST_CAPTURE;
                    end
                end else begin
                    state_nxt_s  = ST_CAPTURE;
                    wr_ptr_nxt_s = wr_ptr_r;
                end
            end
            ST_FULL: begin
                if (run_edge_s) begin
                    state_nxt_s  = ST_CAPTURE;
                    wr_ptr_nxt_s = ADDR_ZERO;
                end else begin
                    state_nxt_s  = ST_FULL;
                    wr_ptr_nxt_s = wr_ptr_r;
                end
            end
            default: begin
                state_nxt_s  = ST_IDLE;
                wr_ptr_nxt_s = ADDR_ZERO;
            end
        endcase
    end

    // Flags follow the next state, so they are mutually exclusive by design.
    assign busy_nxt_s = (state_nxt_s == ST_CAPTURE);
    assign full_nxt_s = (state_nxt_s == ST_FULL);

    // A reset landing on a capture cycle aborts the burst without a write.
    assign wr_en_s = we_s & ~i_rst;

    // RAM write port; no reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= bus.i_data;
        end
    end

    // RAM read port with output register; read-first on address collision.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            data_log_r <= DATA_ZERO;
        end else if (bus.i_read_log) begin
            data_log_r <= mem_r[bus.i_addr_log];
        end
    end

    assign bus.o_data_log = data_log_r;
    assign bus.o_mem_full = full_r;
    assign bus.o_busy     = busy_r;

endmodule

// File: doc/log_mem_ctrl.md
Name: log_mem_ctrl

Overview:
Capture memory that sits directly downstream of the register file's logging controls and upstream of its read-back path. On a run command it records a contiguous burst of samples from the datapath into an internal single-port-write / single-port-read RAM. It raises a full flag when the burst completes. When reading is enabled, it returns the word at the requested address so the register file can present it on GPI.

Parameters:
NB_ADDR_MEM, 15, address width; RAM depth = 2**NB_ADDR_MEM words.
NB_DATA, 32, width of one logged sample word.

Ports:
clk  input  1  system clock; all logic rising-edge.
i_rst  input  1  synchronous active-high reset.
i_run_log  input  1  capture start; a rising edge (0 then 1 on consecutive clocks) starts a burst.
i_read_log  input  1  read enable; level-sensitive.
i_addr_log  input  NB_ADDR_MEM  read address, sampled every clock while i_read_log=1.
i_data  input  NB_DATA  sample word from the datapath.
i_valid  input  1  sample strobe; one word is written per clock with i_valid=1 during capture.
o_data_log  output  NB_DATA  registered read data.
o_mem_full  output  1  burst complete; RAM holds a full capture.
o_busy  output  1  capture in progress.

Behaviour:
- Reset (synchronous, i_rst=1 at a clock edge):
  - FSM goes to IDLE; write pointer = 0; run edge detector register = 0.
  - o_data_log = 0, o_mem_full = 0, o_busy = 0.
  - RAM contents are not cleared.
- FSM states:
  - IDLE -> CAPTURE on a run rising edge (run_d=0 and i_run_log=1).
  - CAPTURE -> FULL when the write at address 2**NB_ADDR_MEM-1 is performed.
  - FULL -> CAPTURE on a run rising edge.
  - There is no transition back to IDLE except through reset.
- Entering CAPTURE:
  - write pointer cleared to 0, o_mem_full cleared to 0, o_busy = 1 from the next cycle.
  - The first write can occur in the first cycle o_busy=1.
- Writing in CAPTURE:
  - On each clock with i_valid=1, RAM[wr_ptr] <= i_data and wr_ptr increments.
  - When i_valid=0 nothing is written and the pointer holds.
- Last write (wr_ptr = max, i_valid=1):
  - Next cycle: o_busy=0, o_mem_full=1, wr_ptr wraps to 0.
  - No further writes occur until the next run edge.
- Run rising edge while in CAPTURE: restart the burst. Pointer goes to 0, o_mem_full stays 0, and the sample present in that same cycle is NOT written.
- A level-high i_run_log held for many cycles is a single edge, so exactly one burst occurs.
- Read path:
  - While i_read_log=1: o_data_log <= RAM[i_addr_log], one clock of latency (address at edge N, data valid after edge N+1).
  - While i_read_log=0: o_data_log holds its last value.
- Reads are permitted in every state. Reading during CAPTURE returns the current RAM content, old or new.
- Read/write collision: if the read address equals the write address in the same cycle, read-first semantics apply and the old word is returned.
- Timing and inference:
  - o_mem_full and o_busy are registered and never both 1.
  - The RAM must infer as block RAM: synchronous write, registered read, no reset on the array.
- Reset asserted mid-capture: the burst is aborted, flags are cleared, and partial data remains in RAM.

Test Plan (NB_ADDR_MEM=4, NB_DATA=32 for the bench):
1. Full burst: reset, then i_run_log 0->1 with i_valid=1 continuously and i_data = 0xA000_0000+n. Expect o_busy=1 for exactly 16 cycles, then o_mem_full=1 and o_busy=0. Read addresses 0..15 with i_read_log=1: o_data_log equals 0xA000_0000..0xA000_000F, each one clock after its address.
2. Gapped valid: i_valid toggling 1,0,1,0 during capture. Expect the burst to take 32 cycles, RAM[k] = the k-th valid sample only, and o_mem_full rising after the 16th valid.
3. Restart mid-burst: a run edge after 5 writes. Expect wr_ptr back at 0 and o_mem_full=0; the completed burst has 16 fresh words starting from the sample after the restart cycle.
4. Held run level: i_run_log held high for 100 cycles with i_valid=1. Expect exactly one burst and o_mem_full=1 from cycle 17 onward, with no re-trigger.
5. Reset mid-capture: i_rst pulsed after 7 writes. Expect o_busy=0, o_mem_full=0, o_data_log=0 the next cycle. Words 0..6 remain readable with their captured values.
6. Read hold and collision:
   - Drop i_read_log: o_data_log stays frozen at its last value.
   - Read address 3 in the same cycle that the write to address 3 occurs: returns the previous content of address 3.
